// File: rtl/divider_ctrl.sv
// Run/stop/step controller and runtime configuration port for a
// toggle-count square-wave divider. The output toggles every
// active_toggle + 1 cycles. It always starts from a clean count and always
// stops on a low level. New ratios take effect only on half-period
// boundaries.
module divider_ctrl #(
  parameter int unsigned     CNT_W          = 33,
  parameter longint unsigned DEFAULT_TOGGLE = 64'd49999999,
  parameter longint unsigned MIN_TOGGLE     = 64'd1,
  parameter int unsigned     PER_W          = 16
) (
  input  logic             clk_in,
  input  logic             rst_n,
  input  logic             start,
  input  logic             stop,
  input  logic             step,
  input  logic             cfg_valid,
  input  logic [CNT_W-1:0] cfg_toggle,
  output logic             cfg_ready,
  output logic             cfg_err,
  output logic             divided_clk,
  output logic             tick,
  output logic             busy,
  output logic [CNT_W-1:0] active_toggle,
  output logic [PER_W-1:0] period_cnt
);

  localparam logic [CNT_W-1:0] DEF_T = CNT_W'(DEFAULT_TOGGLE);
  localparam logic [CNT_W-1:0] MIN_T = CNT_W'(MIN_TOGGLE);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_STOPPING,
    ST_STEP
  } state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] active_q, active_d;
  logic [CNT_W-1:0] pend_q, pend_d;
  logic [PER_W-1:0] per_q, per_d;
  logic             div_q, div_d;
  logic             tick_q, tick_d;
  logic             busy_q, busy_d;
  logic             ready_q, ready_d;
  logic             err_q, err_d;
  logic             pend_valid_q, pend_valid_d;
  // Set for the first cycle after leaving IDLE. A value captured together
  // with start/step can then still be applied while the count is at zero.
  logic             launch_q, launch_d;

  logic boundary;
  logic cfg_fire;
  logic apply;

  // Boundary detection, handshake qualification and the pending-apply point.
  always_comb begin
    boundary = (state_q != ST_IDLE) && (cnt_q == active_q);
    cfg_fire = cfg_valid && ready_q;
    apply    = pend_valid_q && ((state_q == ST_IDLE) || launch_q || boundary);
  end

  // Next-state logic for the FSM, half-period counter, output level and
  // period counter.
  always_comb begin
    // NOTE: every variable gets a default first, so no path can leave a
    // variable unassigned and infer a latch.
    state_d  = state_q;
    cnt_d    = cnt_q;
    div_d    = div_q;
    tick_d   = 1'b0;
    per_d    = per_q;
    launch_d = 1'b0;

    if (state_q != ST_IDLE) begin
      if (boundary) begin
        cnt_d  = '0;
        div_d  = ~div_q;
        tick_d = 1'b1;
        if (!div_q) per_d = per_q + PER_W'(1);
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end

    case (state_q)
      ST_IDLE: begin
        cnt_d = '0;
        div_d = 1'b0;
        // stop beats start. start beats step.
        if (start && !stop) state_d = ST_RUN;
        else if (step)      state_d = ST_STEP;
      end
      ST_RUN, ST_STEP: begin
        if (stop) begin
          if (!div_q) begin
            // Already low: halt at once and cancel any toggle due this cycle.
            state_d = ST_IDLE;
            cnt_d   = '0;
            div_d   = 1'b0;
            tick_d  = 1'b0;
            per_d   = per_q;
          end else if (boundary) begin
            state_d = ST_IDLE;  // the falling edge happens right now
          end else begin
            state_d = ST_STOPPING;
          end
        end else if ((state_q == ST_STEP) && boundary && div_q) begin
          state_d = ST_IDLE;    // second boundary of the step: high then low
        end
      end
      ST_STOPPING: begin
        // Only entered while high, so the next boundary is a falling one.
        if (boundary) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    launch_d = (state_q == ST_IDLE) && (state_d != ST_IDLE);
  end

  // Configuration handshake: reject, capture into pending, and apply.
  always_comb begin
    active_d     = active_q;
    pend_d       = pend_q;
    pend_valid_d = pend_valid_q;
    ready_d      = ready_q;
    err_d        = 1'b0;

    if (apply) begin
      active_d     = pend_q;
      pend_valid_d = 1'b0;
    end

    // ready_q implies nothing is pending, so capture and apply never collide.
    if (cfg_fire) begin
      if (cfg_toggle < MIN_T) begin
        err_d = 1'b1;
      end else begin
        pend_d       = cfg_toggle;
        pend_valid_d = 1'b1;
        ready_d      = 1'b0;
      end
    end else if (!ready_q && !pend_valid_q) begin
      ready_d = 1'b1;   // one cycle after the pending value was applied
    end
  end

  // busy is registered from the next state so it tracks the state register.
  always_comb begin
    busy_d = (state_d != ST_IDLE);
  end

  // State register for every output and internal register.
  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      cnt_q        <= '0;
      div_q        <= 1'b0;
      tick_q       <= 1'b0;
      busy_q       <= 1'b0;
      ready_q      <= 1'b1;
      err_q        <= 1'b0;
      pend_valid_q <= 1'b0;
      pend_q       <= '0;
      active_q     <= DEF_T;
      per_q        <= '0;
      launch_q     <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments make all registers update together
      // from the values they held before the edge.
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      div_q        <= div_d;
      tick_q       <= tick_d;
      busy_q       <= busy_d;
      ready_q      <= ready_d;
      err_q        <= err_d;
      pend_valid_q <= pend_valid_d;
      pend_q       <= pend_d;
      active_q     <= active_d;
      per_q        <= per_d;
      launch_q     <= launch_d;
    end
  end

  assign cfg_ready     = ready_q;
  assign cfg_err       = err_q;
  assign divided_clk   = div_q;
  assign tick          = tick_q;
  assign busy          = busy_q;
  assign active_toggle = active_q;
  assign period_cnt    = per_q;

endmodule

// File: tb/tb_divider_ctrl.sv
// Directed testbench for divider_ctrl. It uses DEFAULT_TOGGLE=4 and PER_W=4
// so that the toggle timing and the period_cnt wrap can be observed in a few
// hundred cycles. Outputs are sampled on the falling clock edge.
module tb_divider_ctrl;

  localparam int unsigned     CNT_W = 33;
  localparam int unsigned     PER_W = 4;
  localparam logic [CNT_W-1:0] DEF_T = 33'd4;

  logic             clk_in;
  logic             rst_n;
  logic             start;
  logic             stop;
  logic             step;
  logic             cfg_valid;
  logic [CNT_W-1:0] cfg_toggle;
  logic             cfg_ready;
  logic             cfg_err;
  logic             divided_clk;
  logic             tick;
  logic             busy;
  logic [CNT_W-1:0] active_toggle;
  logic [PER_W-1:0] period_cnt;

  int n_cmp = 0;
  int n_bad = 0;

  divider_ctrl #(
    .CNT_W         (CNT_W),
    .DEFAULT_TOGGLE(64'd4),
    .MIN_TOGGLE    (64'd1),
    .PER_W         (PER_W)
  ) dut (
    .clk_in       (clk_in),
    .rst_n        (rst_n),
    .start        (start),
    .stop         (stop),
    .step         (step),
    .cfg_valid    (cfg_valid),
    .cfg_toggle   (cfg_toggle),
    .cfg_ready    (cfg_ready),
    .cfg_err      (cfg_err),
    .divided_clk  (divided_clk),
    .tick         (tick),
    .busy         (busy),
    .active_toggle(active_toggle),
    .period_cnt   (period_cnt)
  );

  initial clk_in = 1'b0;
  always #5 clk_in = ~clk_in;

  task automatic do_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk_in);
    rst_n = 1'b1;
    @(negedge clk_in);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk_in);
    n_cmp++;
    if (divided_clk !== 1'b0 || tick !== 1'b0 || busy !== 1'b0 || cfg_ready !== 1'b1 ||
        cfg_err !== 1'b0 || active_toggle !== DEF_T || period_cnt !== 4'd0) begin
      n_bad++;
      $display("FAIL reset_values got div=%b tick=%b busy=%b rdy=%b err=%b act=%0d per=%0d exp 0 0 0 1 0 4 0",
               divided_clk, tick, busy, cfg_ready, cfg_err, active_toggle, period_cnt);
    end
    rst_n = 1'b1;
    @(negedge clk_in);
  endtask

  // Start at E0. The output toggles every 5 cycles, so there are 3 rising
  // edges by E30.
  task automatic test_default_period();
    logic exp_div, exp_tick;
    start = 1'b1; @(negedge clk_in); start = 1'b0;
    n_cmp++;
    if (busy !== 1'b1 || divided_clk !== 1'b0) begin
      n_bad++; $display("FAIL start_busy got busy=%b div=%b exp 1 0", busy, divided_clk);
    end
    for (int k = 1; k <= 30; k++) begin
      @(negedge clk_in);
      exp_div  = ((k / 5) % 2) == 1;
      exp_tick = (k % 5) == 0;
      n_cmp++;
      if (divided_clk !== exp_div || tick !== exp_tick) begin
        n_bad++;
        $display("FAIL default_period k=%0d got div=%b tick=%b exp div=%b tick=%b",
                 k, divided_clk, tick, exp_div, exp_tick);
      end
    end
    n_cmp++;
    if (period_cnt !== 4'd3) begin
      n_bad++; $display("FAIL default_period_cnt got %0d exp 3", period_cnt);
    end
  endtask

  task automatic test_clean_stop();
    logic exp_div;
    // E31..E36: the output rises at E35, and cnt is 1 after E36.
    repeat (6) @(negedge clk_in);
    n_cmp++;
    if (divided_clk !== 1'b1) begin
      n_bad++; $display("FAIL stop_pre_high got %b exp 1", divided_clk);
    end
    stop = 1'b1; @(negedge clk_in); stop = 1'b0;
    for (int k = 0; k < 4; k++) begin
      if (k > 0) @(negedge clk_in);
      exp_div = (k < 3);
      n_cmp++;
      if (divided_clk !== exp_div || tick !== (k == 3)) begin
        n_bad++;
        $display("FAIL stop_high_tail k=%0d got div=%b tick=%b exp div=%b tick=%b",
                 k, divided_clk, tick, exp_div, (k == 3));
      end
    end
    @(negedge clk_in);
    n_cmp++;
    if (busy !== 1'b0) begin
      n_bad++; $display("FAIL stop_busy_clear got %b exp 0", busy);
    end
    for (int k = 0; k < 10; k++) begin
      @(negedge clk_in);
      n_cmp++;
      if (tick !== 1'b0 || divided_clk !== 1'b0) begin
        n_bad++; $display("FAIL stop_quiet k=%0d got div=%b tick=%b exp 0 0", k, divided_clk, tick);
      end
    end
    // A stop while the output is low halts on the next cycle.
    start = 1'b1; @(negedge clk_in); start = 1'b0;
    stop  = 1'b1; @(negedge clk_in); stop  = 1'b0;
    n_cmp++;
    if (busy !== 1'b0 || divided_clk !== 1'b0) begin
      n_bad++; $display("FAIL stop_low got busy=%b div=%b exp 0 0", busy, divided_clk);
    end
    for (int k = 0; k < 6; k++) begin
      @(negedge clk_in);
      n_cmp++;
      if (busy !== 1'b0 || divided_clk !== 1'b0 || tick !== 1'b0) begin
        n_bad++; $display("FAIL stop_low_hold k=%0d got busy=%b div=%b tick=%b exp 0 0 0",
                          k, busy, divided_clk, tick);
      end
    end
  endtask

  // One low phase (E0..E4), one high phase (E5..E9) and a fall at E10.
  // The step pulse at E3 must be ignored.
  task automatic test_single_step();
    logic exp_div, exp_tick;
    step = 1'b1; @(negedge clk_in); step = 1'b0;
    n_cmp++;
    if (busy !== 1'b1 || divided_clk !== 1'b0) begin
      n_bad++; $display("FAIL step_enter got busy=%b div=%b exp 1 0", busy, divided_clk);
    end
    for (int k = 1; k <= 16; k++) begin
      step = (k == 3);
      @(negedge clk_in);
      step = 1'b0;
      exp_div  = (k >= 5) && (k < 10);
      exp_tick = (k == 5) || (k == 10);
      n_cmp++;
      if (divided_clk !== exp_div || tick !== exp_tick) begin
        n_bad++;
        $display("FAIL step_wave k=%0d got div=%b tick=%b exp div=%b tick=%b",
                 k, divided_clk, tick, exp_div, exp_tick);
      end
      if (k <= 9 || k >= 11) begin
        n_cmp++;
        if (busy !== (k <= 9)) begin
          n_bad++; $display("FAIL step_busy k=%0d got %b exp %b", k, busy, (k <= 9));
        end
      end
    end
    n_cmp++;
    if (period_cnt !== 4'd5) begin
      n_bad++; $display("FAIL step_period_cnt got %0d exp 5", period_cnt);
    end
  endtask

  // toggle 9 is offered at E3 (cnt=2). The current half-period still ends at
  // E5, and later toggles come at E15 and E25.
  task automatic test_reconfig();
    logic exp_div, exp_tick;
    int w;
    start = 1'b1; @(negedge clk_in); start = 1'b0;
    cfg_toggle = 33'd9;
    for (int k = 1; k <= 26; k++) begin
      cfg_valid = (k == 3);
      @(negedge clk_in);
      cfg_valid = 1'b0;
      exp_div  = ((k >= 5) && (k < 15)) || (k >= 25);
      exp_tick = (k == 5) || (k == 15) || (k == 25);
      n_cmp++;
      if (divided_clk !== exp_div || tick !== exp_tick) begin
        n_bad++;
        $display("FAIL reconfig_wave k=%0d got div=%b tick=%b exp div=%b tick=%b",
                 k, divided_clk, tick, exp_div, exp_tick);
      end
      if (k == 2) begin
        n_cmp++;
        if (cfg_ready !== 1'b1) begin
          n_bad++; $display("FAIL reconfig_ready_before got %b exp 1", cfg_ready);
        end
      end
      if (k == 3 || k == 4) begin
        n_cmp++;
        if (cfg_ready !== 1'b0 || active_toggle !== DEF_T) begin
          n_bad++; $display("FAIL reconfig_pending k=%0d got rdy=%b act=%0d exp 0 4",
                            k, cfg_ready, active_toggle);
        end
      end
      if (k == 5) begin
        n_cmp++;
        if (cfg_ready !== 1'b0 || active_toggle !== 33'd9) begin
          n_bad++; $display("FAIL reconfig_apply got rdy=%b act=%0d exp 0 9", cfg_ready, active_toggle);
        end
      end
      if (k == 6) begin
        n_cmp++;
        if (cfg_ready !== 1'b1) begin
          n_bad++; $display("FAIL reconfig_ready_after got %b exp 1", cfg_ready);
        end
      end
    end
    n_cmp++;
    if (period_cnt !== 4'd7) begin
      n_bad++; $display("FAIL reconfig_period_cnt got %0d exp 7", period_cnt);
    end
    stop = 1'b1; @(negedge clk_in); stop = 1'b0;
    w = 0;
    while (busy !== 1'b0 && w < 40) begin @(negedge clk_in); w++; end
    n_cmp++;
    if (busy !== 1'b0 || divided_clk !== 1'b0) begin
      n_bad++; $display("FAIL reconfig_stop_drain got busy=%b div=%b exp 0 0", busy, divided_clk);
    end
  endtask

  task automatic test_reject_contention();
    logic exp_div, exp_tick;
    cfg_toggle = 33'd0; cfg_valid = 1'b1; @(negedge clk_in); cfg_valid = 1'b0;
    n_cmp++;
    if (cfg_err !== 1'b1 || cfg_ready !== 1'b1 || active_toggle !== 33'd9) begin
      n_bad++; $display("FAIL reject_err got err=%b rdy=%b act=%0d exp 1 1 9",
                        cfg_err, cfg_ready, active_toggle);
    end
    @(negedge clk_in);
    n_cmp++;
    if (cfg_err !== 1'b0 || active_toggle !== 33'd9) begin
      n_bad++; $display("FAIL reject_err_clear got err=%b act=%0d exp 0 9", cfg_err, active_toggle);
    end
    // start and stop together in IDLE: stop wins.
    start = 1'b1; stop = 1'b1; @(negedge clk_in); start = 1'b0; stop = 1'b0;
    n_cmp++;
    if (busy !== 1'b0) begin
      n_bad++; $display("FAIL start_stop_idle got busy=%b exp 0", busy);
    end
    @(negedge clk_in);
    n_cmp++;
    if (busy !== 1'b0 || divided_clk !== 1'b0) begin
      n_bad++; $display("FAIL start_stop_idle_hold got busy=%b div=%b exp 0 0", busy, divided_clk);
    end
    // Capture together with start. toggle 2 gives 3-cycle half-periods from
    // the first one, so the output toggles at E3 and E6.
    cfg_toggle = 33'd2; cfg_valid = 1'b1; start = 1'b1;
    @(negedge clk_in);
    cfg_valid = 1'b0; start = 1'b0;
    n_cmp++;
    if (busy !== 1'b1 || cfg_ready !== 1'b0) begin
      n_bad++; $display("FAIL cap_start got busy=%b rdy=%b exp 1 0", busy, cfg_ready);
    end
    for (int k = 1; k <= 6; k++) begin
      @(negedge clk_in);
      exp_div  = (k >= 3) && (k < 6);
      exp_tick = (k == 3) || (k == 6);
      n_cmp++;
      if (divided_clk !== exp_div || tick !== exp_tick) begin
        n_bad++;
        $display("FAIL cap_start_wave k=%0d got div=%b tick=%b exp div=%b tick=%b",
                 k, divided_clk, tick, exp_div, exp_tick);
      end
      if (k == 1) begin
        n_cmp++;
        if (active_toggle !== 33'd2 || cfg_ready !== 1'b0) begin
          n_bad++; $display("FAIL cap_start_apply got act=%0d rdy=%b exp 2 0", active_toggle, cfg_ready);
        end
      end
      if (k == 2) begin
        n_cmp++;
        if (cfg_ready !== 1'b1) begin
          n_bad++; $display("FAIL cap_start_ready got %b exp 1", cfg_ready);
        end
      end
    end
    stop = 1'b1; @(negedge clk_in); stop = 1'b0;
    n_cmp++;
    if (busy !== 1'b0 || divided_clk !== 1'b0) begin
      n_bad++; $display("FAIL cap_start_stop got busy=%b div=%b exp 0 0", busy, divided_clk);
    end
  endtask

  // With toggle 1 the period is 4 cycles, and rising edges come at E2+4m.
  // The 16th rising edge (E62) wraps the 4-bit counter from 15 to 0.
  task automatic test_wrap();
    int exp_per;
    int w;
    do_reset();
    cfg_toggle = 33'd1; cfg_valid = 1'b1; @(negedge clk_in); cfg_valid = 1'b0;
    @(negedge clk_in);
    n_cmp++;
    if (active_toggle !== 33'd1) begin
      n_bad++; $display("FAIL wrap_cfg got act=%0d exp 1", active_toggle);
    end
    @(negedge clk_in);
    start = 1'b1; @(negedge clk_in); start = 1'b0;
    for (int k = 1; k <= 66; k++) begin
      @(negedge clk_in);
      exp_per = ((k >= 2) ? ((k - 2) / 4 + 1) : 0) % 16;
      n_cmp++;
      if (period_cnt !== PER_W'(exp_per)) begin
        n_bad++; $display("FAIL wrap_period_cnt k=%0d got %0d exp %0d", k, period_cnt, exp_per);
      end
    end
    stop = 1'b1; @(negedge clk_in); stop = 1'b0;
    w = 0;
    while (busy !== 1'b0 && w < 20) begin @(negedge clk_in); w++; end
    n_cmp++;
    if (busy !== 1'b0 || divided_clk !== 1'b0) begin
      n_bad++; $display("FAIL wrap_stop_drain got busy=%b div=%b exp 0 0", busy, divided_clk);
    end
  endtask

  // Reset in the middle of a high phase, while a value is pending.
  task automatic test_async_reset();
    start = 1'b1; @(negedge clk_in); start = 1'b0;
    @(negedge clk_in);
    cfg_toggle = 33'd7; cfg_valid = 1'b1; @(negedge clk_in); cfg_valid = 1'b0;
    n_cmp++;
    if (divided_clk !== 1'b1 || cfg_ready !== 1'b0) begin
      n_bad++; $display("FAIL areset_pre got div=%b rdy=%b exp 1 0", divided_clk, cfg_ready);
    end
    #2 rst_n = 1'b0;
    #1;
    n_cmp++;
    if (divided_clk !== 1'b0 || busy !== 1'b0 || active_toggle !== DEF_T || tick !== 1'b0 ||
        period_cnt !== 4'd0 || cfg_ready !== 1'b1) begin
      n_bad++;
      $display("FAIL areset_immediate got div=%b busy=%b act=%0d tick=%b per=%0d rdy=%b exp 0 0 4 0 0 1",
               divided_clk, busy, active_toggle, tick, period_cnt, cfg_ready);
    end
    @(negedge clk_in);
    rst_n = 1'b1;
    repeat (3) @(negedge clk_in);
    n_cmp++;
    if (active_toggle !== DEF_T || busy !== 1'b0 || divided_clk !== 1'b0 || cfg_ready !== 1'b1) begin
      n_bad++; $display("FAIL areset_discard got act=%0d busy=%b div=%b rdy=%b exp 4 0 0 1",
                        active_toggle, busy, divided_clk, cfg_ready);
    end
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; stop = 1'b0; step = 1'b0;
    cfg_valid = 1'b0; cfg_toggle = '0;
    test_reset();
    test_default_period();
    test_clean_stop();
    test_single_step();
    test_reconfig();
    test_reject_contention();
    test_wrap();
    test_async_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/divider_ctrl.md
Name: divider_ctrl

Overview:
- Run/stop/step controller and runtime configuration port for the board's square-wave clock divider (toggle-count scheme: output toggles every TOGGLE+1 input cycles).
- Sequences the divider so it always starts from a clean count and always stops on a low level.
- Applies new divide ratios only on half-period boundaries, so no runt pulses are produced.
- Provides a one-cycle tick per toggle and a period counter for downstream logic such as display refresh and the step-through conversion demo.

Parameters:
- CNT_W, 33, width of the half-period counter and the toggle value.
- DEFAULT_TOGGLE, 49999999, toggle value loaded at reset (1 Hz output from 100 MHz).
- MIN_TOGGLE, 1, smallest accepted configuration value.
- PER_W, 16, width of the period counter.

Ports:
- clk_in  in  1  system clock.
- rst_n  in  1  reset: asynchronous, active-low.
- start  in  1  one-cycle pulse: IDLE -> RUN.
- stop  in  1  one-cycle pulse: request a clean stop.
- step  in  1  one-cycle pulse: produce exactly one full output period, then IDLE.
- cfg_valid  in  1  new toggle value offered.
- cfg_toggle  in  CNT_W  offered toggle value.
- cfg_ready  out  1  controller can accept a value.
- cfg_err  out  1  one-cycle pulse: offered value rejected.
- divided_clk  out  1  divided square wave.
- tick  out  1  one-cycle pulse on every divided_clk toggle.
- busy  out  1  high in any state other than IDLE.
- active_toggle  out  CNT_W  toggle value currently in force.
- period_cnt  out  PER_W  count of divided_clk rising edges.

Behaviour:
- Reset values: state IDLE, cnt 0, divided_clk 0, tick 0, busy 0, cfg_ready 1, cfg_err 0, pending-valid 0, active_toggle DEFAULT_TOGGLE, period_cnt 0.
- Reset mid-operation forces these values immediately and discards any pending configuration.
- All outputs are registered.
- States:
  - IDLE: cnt held at 0, divided_clk 0.
  - RUN: free-running output.
  - STOPPING: waiting for a clean low level.
  - STEP: producing one full period.
- Boundary event: cnt == active_toggle in RUN, STOPPING or STEP.
- On a boundary:
  - cnt <= 0; divided_clk <= ~divided_clk; tick = 1 in the same registered update.
  - If divided_clk goes 0->1, period_cnt increments, wrapping to 0 at all-ones.
- Between boundaries: cnt <= cnt + 1, and tick = 0.
- Half-period is active_toggle + 1 cycles.
- Transitions:
  - IDLE + start -> RUN.
  - IDLE + step -> STEP.
  - start and step together in IDLE: start wins.
  - RUN + stop:
    - If divided_clk == 0, go to IDLE next cycle with cnt cleared and no tick.
    - Otherwise go to STOPPING.
  - STOPPING: at the boundary that drives divided_clk 1->0, go to IDLE.
  - STEP: after the second boundary (high then low), go to IDLE.
  - stop in STEP aborts the step using the same rule as in RUN.
  - start in RUN, STOPPING or STEP is ignored; step outside IDLE is ignored.
  - start and stop in the same cycle: stop wins (start ignored).
- Configuration handshake:
  - Transfer occurs on cfg_valid & cfg_ready.
  - If cfg_toggle < MIN_TOGGLE: value is not captured, cfg_err pulses on the next cycle, cfg_ready stays 1.
  - Otherwise the value is written to the pending register and cfg_ready drops to 0.
- Applying the pending value:
  - IDLE: active_toggle <= pending on the cycle after capture.
  - RUN, STOPPING, STEP: applied on the next boundary, simultaneously with cnt <= 0, so the following half-period uses the new value.
  - cfg_ready returns to 1 on the cycle after the pending value is applied.
- Config capture and start in the same IDLE cycle:
  - The value is applied on the following cycle, while cnt is still 0.
  - The first half-period uses the new value.

Test Plan:
- Default period: DEFAULT_TOGGLE=4, reset, start at cycle 0.
  - divided_clk toggles every 5 cycles.
  - tick pulses once per toggle.
  - period_cnt = 3 after 30 cycles.
- Clean stop: stop while divided_clk=1 with cnt=1.
  - Output stays high 3 more cycles, falls, busy=0 on the next cycle.
  - No further ticks.
  - Stop while divided_clk=0: busy=0 next cycle, output remains 0.
- Single step: step in IDLE with toggle 4.
  - Exactly one high phase of 5 cycles and one low phase of 5 cycles.
  - period_cnt +1, then IDLE.
  - A second step pulse during STEP has no effect.
- Runtime reconfiguration: in RUN, offer cfg_toggle=9 mid half-period.
  - cfg_ready low until the next boundary.
  - Current half-period stays 5 cycles; subsequent half-periods are 10 cycles.
  - active_toggle=9.
- Rejection and contention:
  - cfg_toggle=0 -> cfg_err one cycle, active_toggle unchanged.
  - start+stop same cycle in IDLE -> remains IDLE.
  - period_cnt wraps 0xFFFF -> 0 (preload via reset plus long run with PER_W=4 override: 15 -> 0).
- Async reset: assert rst_n low mid high phase.
  - divided_clk=0, busy=0 and active_toggle=DEFAULT_TOGGLE immediately, before any clk_in edge.
